mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the CPU's single unified memory port between the instruction-fetch requester and the load/store requester.
- Registered FSM that grants one requester at a time and drives the memory request/acknowledge handshake.
- Returns read data with a one-cycle ready pulse.
- Bounds memory latency with a timeout; the CPU's halt gates new grants.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, memory data width
STARVE_MAX, 4, max consecutive data grants while a fetch is pending (min 1)
TIMEOUT, 255, cycles in BUSY without mem_ack before abort; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
halt  in  1  CPU halted: no new grants; an in-flight access completes
if_valid  in  1  fetch request, held until if_ready
if_addr  in  ADDR_W  fetch address
if_ready  out  1  one-cycle pulse: fetch complete
if_rdata  out  DATA_W  fetch data, valid with if_ready
d_valid  in  1  data request, held until d_ready
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  byte enables
d_ready  out  1  one-cycle pulse: data access complete
d_rdata  out  DATA_W  load data, valid with d_ready
err  out  1  with ready: access aborted by timeout
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_ack  in  1  memory done; mem_rdata valid this cycle
mem_rdata  in  DATA_W  memory read data
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; streak counter 0; timeout counter 0.
- The async reset clears the FSM immediately, including mid-access. mem_req drops at once; the memory side must tolerate an abandoned request.
- States: IDLE, BUSY, RESP.
- IDLE arbitration:
  - If halt = 1, stay in IDLE.
  - Otherwise, if d_valid and (!if_valid or streak < STARVE_MAX), grant data.
  - Otherwise, if if_valid, grant fetch.
  - On grant, latch requester id, addr, we (fetch: 0), wdata, be (fetch: all ones) into the mem_* registers. Set mem_req = 1 and go to BUSY.
- Streak counter:
  - Increments on each data grant made while if_valid = 1; saturates at STARVE_MAX.
  - Clears on any fetch grant.
  - Clears on a data grant with if_valid = 0.
- BUSY:
  - mem_* outputs stay stable.
  - On mem_ack: capture mem_rdata into the granted requester's rdata (stores capture 0). Set err = 0, drop mem_req, go to RESP.
  - Else, if TIMEOUT != 0 and the counter reaches TIMEOUT-1: drop mem_req, set rdata = 0, err = 1, go to RESP.
  - The counter increments each BUSY cycle and clears on BUSY entry.
- RESP:
  - Exactly one cycle. The granted requester's ready = 1 and the other ready = 0.
  - No arbitration takes place in this cycle. Next state is IDLE.
  - The requester must drop or update its valid on the edge ending RESP.
- Latency: valid seen in IDLE at cycle 0 gives mem_req at cycle 1. mem_ack at cycle k gives ready at cycle k+1. Minimum 3 cycles when mem_ack returns in the first BUSY cycle.
- Minimum spacing between grants: IDLE, BUSY, RESP, i.e. 3 cycles.
- halt asserted while in BUSY or RESP: the access completes normally; the next IDLE holds.
- mem_ack while in IDLE or RESP is ignored.
- if_rdata and d_rdata hold their last value outside the ready pulse. err is cleared on entry to BUSY.

Decomposition:
- Shared package: FSM state encoding (IDLE, BUSY, RESP) and requester id constants (REQ_IF = 0, REQ_D = 1).
- Natural sub-module: mem_timeout_ctr, the loadable up-counter with terminal flag and disable when TIMEOUT = 0.
- Arbitration and streak logic stay in the top module.

Test Plan:
- Single fetch: if_valid with if_addr = 0x00000040, mem_ack one cycle after mem_req, mem_rdata = 0x8C010004 -> mem_req at cycle 1, if_ready at cycle 3 with if_rdata = 0x8C010004, err = 0.
- Simultaneous requests: if_valid and d_valid (load, addr 0x100) both at cycle 0 -> data granted first. Fetch granted in the next IDLE and completes after it. Exactly one ready per RESP.
- Starvation guard: STARVE_MAX = 4, d_valid and if_valid held continuously -> 4 data grants, then 1 fetch grant, repeating. Streak counter resets after each fetch.
- Store path: d_we = 1, d_addr = 0x200, d_wdata = 0xDEADBEEF, d_be = 0b0011 -> mem_we = 1 with matching mem_addr, mem_wdata and mem_be stable throughout BUSY. d_ready pulses and d_rdata = 0.
- Timeout: TIMEOUT = 8, mem_ack never asserted -> mem_req high for exactly 8 cycles, then the granted ready pulses with err = 1 and rdata = 0, busy returns to 0.
- Halt and reset:
  - halt = 1 asserted during BUSY -> the current access completes, if_valid is then never granted while halt = 1, and it is granted on the cycle after halt drops.
  - rst asserted mid-BUSY -> mem_req, busy and ready are 0 immediately (asynchronously).

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
module mem_timeout_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && en && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                halt,
  input  logic                if_valid,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_valid,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_t        state, state_next;
  logic          gnt;
  logic [SW-1:0] streak;
  logic          grant;
  logic          grant_id;
  logic          done;
  logic          abort;
  logic          tmo_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_id   = REQ_IF;
    done       = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!halt) begin
          if (d_valid && (!if_valid || (streak < STARVE_LIM))) begin
            grant    = 1'b1;
            grant_id = REQ_D;
          end else if (if_valid) begin
            grant    = 1'b1;
            grant_id = REQ_IF;
          end
        end
        if (grant) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          done       = 1'b1;
          state_next = RESP;
        end else if (tmo_hit) begin
          abort      = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= REQ_IF;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      if (grant) begin
        gnt     <= grant_id;
        mem_req <= 1'b1;
        err     <= 1'b0;
        if (grant_id == REQ_D) begin
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          mem_be    <= d_be;
          if (!if_valid) begin
            streak <= '0;
          end else if (streak != STARVE_LIM) begin
            streak <= streak + SW'(1);
          end
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          mem_be    <= '1;
          streak    <= '0;
        end
      end
      if (done || abort) begin
        mem_req <= 1'b0;
        err     <= abort;
        if (gnt == REQ_IF) begin
          if_rdata <= (done && !mem_we) ? mem_rdata : '0;
        end else begin
          d_rdata  <= (done && !mem_we) ? mem_rdata : '0;
        end
      end
    end
  end

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant),
    .en     (state == BUSY),
    .expired(tmo_hit)
  );

  assign busy     = (state != IDLE);
  assign if_ready = (state == RESP) && (gnt == REQ_IF);
  assign d_ready  = (state == RESP) && (gnt == REQ_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int TMO  = 8;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_valid = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(SMAX),
    .TIMEOUT   (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .halt     (halt),
    .if_valid (if_valid),
    .if_addr  (if_addr),
    .if_ready (if_ready),
    .if_rdata (if_rdata),
    .d_valid  (d_valid),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .err      (err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Transaction-level reference: phase 0 idle, 1 access outstanding, 2 response cycle
  int          m_phase;
  int          m_streak;
  int          m_busy_n;
  bit          m_gnt_d;
  bit          m_err;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wd;
  logic [3:0]  m_be;
  logic [31:0] m_if_rd;
  logic [31:0] m_d_rd;

  task automatic model_reset();
    m_phase = 0; m_streak = 0; m_busy_n = 0; m_gnt_d = 0; m_err = 0; m_we = 0;
    m_addr = '0; m_wd = '0; m_be = '0; m_if_rd = '0; m_d_rd = '0;
  endtask

  task automatic model_step();
    case (m_phase)
      0: begin
        if (!halt && (if_valid || d_valid)) begin
          if (d_valid && (!if_valid || m_streak < SMAX)) begin
            m_gnt_d = 1; m_we = d_we; m_addr = d_addr; m_wd = d_wdata; m_be = d_be;
            m_streak = if_valid ? ((m_streak + 1 > SMAX) ? SMAX : m_streak + 1) : 0;
          end else begin
            m_gnt_d = 0; m_we = 0; m_addr = if_addr; m_be = 4'hF;
            m_streak = 0;
          end
          m_phase = 1; m_busy_n = 0; m_err = 0;
        end
      end
      1: begin
        m_busy_n++;
        if (mem_ack) begin
          m_phase = 2; m_err = 0;
          if (m_gnt_d) m_d_rd = m_we ? 32'h0 : mem_rdata;
          else         m_if_rd = mem_rdata;
        end else if (m_busy_n == TMO) begin
          m_phase = 2; m_err = 1;
          if (m_gnt_d) m_d_rd = '0;
          else         m_if_rd = '0;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic compare_all();
    check_eq("busy", busy, m_phase != 0);
    check_eq("mem_req", mem_req, m_phase == 1);
    if (m_phase == 1) begin
      check_eq("mem_we", mem_we, m_we);
      check_eq("mem_addr", mem_addr, m_addr);
      check_eq("mem_be", mem_be, m_be);
      if (m_we) check_eq("mem_wdata", mem_wdata, m_wd);
    end
    check_eq("if_ready", if_ready, m_phase == 2 && !m_gnt_d);
    check_eq("d_ready", d_ready, m_phase == 2 && m_gnt_d);
    check_eq("err", err, m_err);
    check_eq("if_rdata", if_rdata, m_if_rd);
    check_eq("d_rdata", d_rdata, m_d_rd);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  // Memory responder
  int          force_lat = -1;
  bit          spur_en = 0;
  bit          force_rd_en = 0;
  logic [31:0] force_rd = '0;
  int          mem_wait = 0;
  int          lat = 0;

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14) return r % 4;
    if (r < 17) return TMO - 1;
    return 1000;
  endfunction

  task automatic drive_mem();
    mem_rdata = force_rd_en ? force_rd : 32'($urandom);
    if (mem_req) begin
      if (mem_wait == 0) lat = (force_lat >= 0) ? force_lat : pick_lat();
      mem_ack = (mem_wait == lat);
      mem_wait++;
    end else begin
      mem_wait = 0;
      mem_ack = spur_en && ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic step();
    drive_mem();
    cycle();
  endtask

  task automatic rand_reqs();
    if (if_ready) if_valid = 0;
    if (!if_valid && $urandom_range(0, 2) == 0) begin
      if_valid = 1;
      if_addr  = 32'($urandom) & ~32'h3;
    end
    if (d_ready) d_valid = 0;
    if (!d_valid && $urandom_range(0, 2) == 0) begin
      d_valid = 1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = 32'($urandom);
      d_wdata = 32'($urandom);
      d_be    = 4'($urandom);
    end
    if (halt) halt = ($urandom_range(0, 7) != 0);
    else      halt = ($urandom_range(0, 39) == 0);
  endtask

  task automatic do_reset();
    if_valid = 0; d_valid = 0; d_we = 0; halt = 0; mem_ack = 0;
    rst = 1;
    model_reset();
    mem_wait = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    compare_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nreq;
    int got;
    int both;
    int ng;
    int prev;
    int ord[2];
    int ids[10];

    // Reset state
    do_reset();
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_busy", busy, 0);

    // Single fetch
    force_lat = 1; force_rd_en = 1; force_rd = 32'h8C010004;
    if_valid = 1; if_addr = 32'h40;
    n = 0;
    while (!if_ready && n < 20) begin
      step();
      n++;
      if (n == 1) check_eq("fetch_req_c1", mem_req, 1);
    end
    check_eq("fetch_lat", n, 3);
    check_eq("fetch_rdata", if_rdata, 32'h8C010004);
    check_eq("fetch_err", err, 0);
    if_valid = 0; force_rd_en = 0;

    // Simultaneous requests
    do_reset();
    force_lat = 1;
    if_valid = 1; if_addr = 32'h80;
    d_valid = 1; d_we = 0; d_addr = 32'h100;
    got = 0; both = 0; n = 0;
    while (got < 2 && n < 40) begin
      step();
      n++;
      if (if_ready && d_ready) both++;
      if (d_ready && got < 2) begin ord[got] = 1; got++; d_valid = 0; end
      if (if_ready && got < 2) begin ord[got] = 0; got++; if_valid = 0; end
    end
    check_eq("simul_done", got, 2);
    check_eq("simul_first_is_data", ord[0], 1);
    check_eq("simul_second_is_fetch", ord[1], 0);
    check_eq("simul_one_ready", both, 0);

    // Starvation guard
    do_reset();
    force_lat = 0;
    if_valid = 1; if_addr = 32'h1000;
    d_valid = 1; d_we = 0; d_addr = 32'h2000;
    ng = 0; prev = 0; n = 0;
    while (ng < 10 && n < 200) begin
      step();
      n++;
      if (mem_req && prev == 0) begin
        ids[ng] = (mem_addr == 32'h2000) ? 1 : 0;
        ng++;
      end
      prev = mem_req;
    end
    check_eq("starve_grants", ng, 10);
    for (int i = 0; i < 10; i++)
      check_eq($sformatf("starve_g%0d", i), ids[i], (i % 5 != 4) ? 1 : 0);

    // Store path
    do_reset();
    force_lat = 2;
    d_valid = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    n = 0;
    while (!d_ready && n < 20) begin
      step();
      n++;
      if (mem_req) begin
        check_eq("store_we", mem_we, 1);
        check_eq("store_addr", mem_addr, 32'h200);
        check_eq("store_wdata", mem_wdata, 32'hDEADBEEF);
        check_eq("store_be", mem_be, 4'b0011);
      end
    end
    check_eq("store_lat", n, 4);
    check_eq("store_rdata", d_rdata, 0);
    check_eq("store_err", err, 0);
    d_valid = 0; d_we = 0;

    // Timeout
    force_lat = 1000;
    if_valid = 1; if_addr = 32'h300;
    n = 0; nreq = 0;
    while (!if_ready && n < 30) begin
      step();
      n++;
      if (mem_req) nreq++;
    end
    check_eq("tmo_req_cycles", nreq, TMO);
    check_eq("tmo_err", err, 1);
    check_eq("tmo_rdata", if_rdata, 0);
    if_valid = 0;
    step();
    check_eq("tmo_busy_clear", busy, 0);

    // Halt during an access
    do_reset();
    force_lat = 2;
    if_valid = 1; if_addr = 32'h400;
    n = 0;
    while (!mem_req && n < 5) begin step(); n++; end
    halt = 1;
    while (!if_ready && n < 20) begin step(); n++; end
    check_eq("halt_completes", if_ready, 1);
    if_addr = 32'h404;
    repeat (6) begin
      step();
      check_eq("halt_no_grant", mem_req, 0);
    end
    force_lat = 1000;
    halt = 0;
    step();
    check_eq("halt_release_grant", mem_req, 1);
    check_eq("halt_release_addr", mem_addr, 32'h404);

    // Asynchronous reset mid-access
    repeat (2) step();
    #2 rst = 1;
    #1;
    check_eq("arst_mem_req", mem_req, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_if_ready", if_ready, 0);
    check_eq("arst_d_ready", d_ready, 0);
    model_reset();
    mem_wait = 0; if_valid = 0; mem_ack = 0;
    @(negedge clk);
    rst = 0;
    compare_all();

    // Randomized traffic
    force_lat = -1; spur_en = 1;
    repeat (3000) begin
      rand_reqs();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
